// File: rtl/hex_record_formatter_pkg.sv
// -----------------------------------------------------------------------------
// hex_fmt_pkg
// Shared definitions for the hex record formatter:
//   - ASCII constants for the separator, line terminator and hex digit bases
//   - FSM state encoding (the SEQ_* states are only reachable when the
//     HEX_FMT_SEQ_EN build macro is defined)
// -----------------------------------------------------------------------------
package hex_fmt_pkg;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIGIT,
        ST_SPACE,
        ST_LF,
        ST_CR,
        ST_SEQ_HI,
        ST_SEQ_LO,
        ST_SEQ_SP
    } state_e;

endpackage

// File: rtl/hex_record_formatter_if.sv
// -----------------------------------------------------------------------------
// hex_record_formatter_if
// Record-in / byte-out handshake bundle of the hex record formatter.
//   in_data/in_valid/in_ready : upstream FIFO read port (pop on valid&&ready)
//   out_data/out_strobe       : byte write into the UART tx FIFO
//   out_ready                 : tx FIFO not full
// Modports:
//   master : the formatter itself
//   slave  : the surrounding FIFOs (or a testbench standing in for them)
// -----------------------------------------------------------------------------
interface hex_record_formatter_if #(
    parameter int WIDTH = 28
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_strobe;
    logic             out_ready;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_strobe
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_strobe
    );
endinterface

// File: rtl/hex_record_formatter_ascii.sv
// -----------------------------------------------------------------------------
// hex_nibble_to_ascii
// Combinational 4-bit value to ASCII hex digit.
//   nibble : value 0..15
//   ascii  : '0'..'9', then 'a'..'f' (UPPERCASE=0) or 'A'..'F' (UPPERCASE=1)
// -----------------------------------------------------------------------------
module hex_nibble_to_ascii
    import hex_fmt_pkg::*;
#(
    parameter bit UPPERCASE = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    localparam logic [7:0] ALPHA_BASE = UPPERCASE ? ASCII_UPPER_A : ASCII_LOWER_A;

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'h0, nibble};
        end else begin
            ascii = ALPHA_BASE + {4'h0, nibble} - 8'd10;
        end
    end
endmodule

// File: rtl/hex_record_formatter.sv
// -----------------------------------------------------------------------------
// hex_record_formatter
// Pops one WIDTH-bit record from the upstream FIFO and writes it to the UART
// tx FIFO as an ASCII hex line: MSB digit first, an optional space before the
// last SPLIT digits, then LF, CR. Both sides are backpressured, so a record is
// never dropped or interleaved with the next one.
//
// Parameters:
//   WIDTH     record width; NIBBLES = ceil(WIDTH/4), pad bits read as zero
//   SPLIT     space before the last SPLIT digits (0 or >= NIBBLES: no space)
//   UPPERCASE 1 = 'A'-'F', 0 = 'a'-'f'
// Ports:
//   clk    system clock
//   reset  synchronous, active-low reset
//   bus    hex_record_formatter_if.master (record in, byte out)
//   busy   high while a record is being emitted
// Build option:
//   HEX_FMT_SEQ_EN  prefix every line with an 8-bit record sequence number
//                   as two hex digits and a space (wraps 0xFF -> 0x00)
// -----------------------------------------------------------------------------
module hex_record_formatter
    import hex_fmt_pkg::*;
#(
    parameter int WIDTH     = 28,
    parameter int SPLIT     = 5,
    parameter int UPPERCASE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_record_formatter_if.master  bus,
    output logic                    busy
);
    localparam int NIBBLES   = (WIDTH + 3) / 4;
    localparam int SR_W      = NIBBLES * 4;
    localparam int CNT_W     = $clog2(NIBBLES + 1);
    localparam bit SPLIT_EN  = (SPLIT > 0) && (SPLIT < NIBBLES);
    localparam logic [CNT_W-1:0] NIB_CNT   = CNT_W'(NIBBLES);
    localparam logic [CNT_W-1:0] SPLIT_CNT = CNT_W'(SPLIT);

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_dec;
    logic [SR_W-1:0]   padded;
    logic [7:0]        digit_ascii;
    logic              emit_ok;
    logic              pop_ok;

    // Outputs are qualified with reset so a record cannot be popped (and
    // lost) or a byte strobed while reset is being held.
    assign emit_ok = bus.out_ready & reset;
    assign pop_ok  = bus.in_valid & reset;
    assign cnt_dec = cnt_q - CNT_W'(1);
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        padded              = '0;
        padded[WIDTH-1:0]   = bus.in_data;
    end

    hex_nibble_to_ascii #(.UPPERCASE(UPPERCASE != 0)) u_digit (
        .nibble (sr_q[SR_W-1 -: 4]),
        .ascii  (digit_ascii)
    );

`ifdef HEX_FMT_SEQ_EN
    logic [7:0] seq_q, seq_d;
    logic [3:0] seq_nibble;
    logic [7:0] seq_ascii;

    assign seq_nibble = (state_q == ST_SEQ_HI) ? seq_q[7:4] : seq_q[3:0];

    hex_nibble_to_ascii #(.UPPERCASE(UPPERCASE != 0)) u_seq (
        .nibble (seq_nibble),
        .ascii  (seq_ascii)
    );

    localparam state_e FIRST_ST = ST_SEQ_HI;
`else
    localparam state_e FIRST_ST = ST_DIGIT;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        sr_d           = sr_q;
        cnt_d          = cnt_q;
        bus.in_ready   = 1'b0;
        bus.out_strobe = 1'b0;
        bus.out_data   = 8'h00;
`ifdef HEX_FMT_SEQ_EN
        seq_d          = seq_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                bus.in_ready = pop_ok;
                if (pop_ok) begin
                    sr_d    = padded;
                    cnt_d   = NIB_CNT;
                    state_d = FIRST_ST;
                end
            end

            ST_DIGIT: begin
                bus.out_data = digit_ascii;
                if (emit_ok) begin
                    bus.out_strobe = 1'b1;
                    sr_d           = sr_q << 4;
                    cnt_d          = cnt_dec;
                    // The space sits between the digit that leaves SPLIT
                    // digits remaining and the next one.
                    if (cnt_dec == '0) begin
                        state_d = ST_LF;
                    end else if (SPLIT_EN && (cnt_dec == SPLIT_CNT)) begin
                        state_d = ST_SPACE;
                    end
                end
            end

            ST_SPACE: begin
                bus.out_data = ASCII_SPACE;
                if (emit_ok) begin
                    bus.out_strobe = 1'b1;
                    state_d        = ST_DIGIT;
                end
            end

            ST_LF: begin
                bus.out_data = ASCII_LF;
                if (emit_ok) begin
                    bus.out_strobe = 1'b1;
                    state_d        = ST_CR;
                end
            end

            ST_CR: begin
                bus.out_data = ASCII_CR;
                if (emit_ok) begin
                    bus.out_strobe = 1'b1;
                    state_d        = ST_IDLE;
`ifdef HEX_FMT_SEQ_EN
                    seq_d          = seq_q + 8'd1;
`endif
                end
            end

`ifdef HEX_FMT_SEQ_EN
            ST_SEQ_HI: begin
                bus.out_data = seq_ascii;
                if (emit_ok) begin
                    bus.out_strobe = 1'b1;
                    state_d        = ST_SEQ_LO;
                end
            end

            ST_SEQ_LO: begin
                bus.out_data = seq_ascii;
                if (emit_ok) begin
                    bus.out_strobe = 1'b1;
                    state_d        = ST_SEQ_SP;
                end
            end

            ST_SEQ_SP: begin
                bus.out_data = ASCII_SPACE;
                if (emit_ok) begin
                    bus.out_strobe = 1'b1;
                    state_d        = ST_DIGIT;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; it only acts on a clock edge, which
        // is why the outputs above are also gated while it is held.
        if (!reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HEX_FMT_SEQ_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_q <= 8'h00;
        end else begin
            seq_q <= seq_d;
        end
    end
`endif

endmodule

// File: tb/tb_hex_record_formatter.sv
// -----------------------------------------------------------------------------
// tb_hex_record_formatter
// Directed and randomized checks of hex_record_formatter against a line model
// built from the output format rules. Two instances: the default build
// (WIDTH=28, SPLIT=5, lowercase) and a narrow one (WIDTH=10, SPLIT=0,
// uppercase). Honors HEX_FMT_SEQ_EN for the sequence prefix.
// -----------------------------------------------------------------------------
module tb_hex_record_formatter;

    localparam int W1 = 28, S1 = 5, U1 = 0;
    localparam int W2 = 10, S2 = 0, U2 = 1;
`ifdef HEX_FMT_SEQ_EN
    localparam int PFX = 3;
`else
    localparam int PFX = 0;
`endif
    localparam int BYTES1 = PFX + 7 + 1 + 2;
    localparam int BYTES2 = PFX + 3 + 0 + 2;

    logic clk = 1'b0;
    logic reset;
    logic busy1, busy2;

    always #5 clk = ~clk;

    hex_record_formatter_if #(.WIDTH(W1)) if1 ();
    hex_record_formatter_if #(.WIDTH(W2)) if2 ();

    hex_record_formatter #(.WIDTH(W1), .SPLIT(S1), .UPPERCASE(U1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1), .busy(busy1)
    );
    hex_record_formatter #(.WIDTH(W2), .SPLIT(S2), .UPPERCASE(U2)) dut2 (
        .clk(clk), .reset(reset), .bus(if2), .busy(busy2)
    );

    int          compared   = 0;
    int          mismatched = 0;
    int          viol;
    int          sel;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] word_q[$];
    int          pop_cyc[$];
    int          strobe_cyc[$];
    logic [7:0]  seq_m[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input int n, input bit upper);
        if (n < 10) return 8'(48 + n);
        return 8'((upper ? 65 : 97) + n - 10);
    endfunction

    function automatic logic [7:0] byte_at(input logic [7:0] q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return 8'hxx;
    endfunction

    function automatic int int_at(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    // Expected text of one line, appended to exp_q.
    task automatic expect_line(input logic [31:0] word);
        int w, s, nib;
        bit up;
        w   = (sel == 0) ? W1 : W2;
        s   = (sel == 0) ? S1 : S2;
        up  = (sel == 0) ? (U1 != 0) : (U2 != 0);
        nib = (w + 3) / 4;
`ifdef HEX_FMT_SEQ_EN
        exp_q.push_back(hex_char(int'(seq_m[sel]) / 16, up));
        exp_q.push_back(hex_char(int'(seq_m[sel]) % 16, up));
        exp_q.push_back(8'h20);
        seq_m[sel] = seq_m[sel] + 8'd1;
`endif
        for (int i = nib - 1; i >= 0; i--) begin
            exp_q.push_back(hex_char(int'((word >> (4 * i)) & 32'hF), up));
            if (s > 0 && s < nib && i == s) exp_q.push_back(8'h20);
        end
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0D);
    endtask

    task automatic clear_log();
        exp_q.delete();
        got_q.delete();
        word_q.delete();
        pop_cyc.delete();
        strobe_cyc.delete();
        viol = 0;
    endtask

    // Presents word_q to the selected DUT and logs every strobed byte.
    // mode: 0 = out_ready always 1, 1 = toggling 1,0,1,0, 2 = random.
    task automatic run_words(input int mode, input int budget);
        bit          done;
        bit          cur_valid, rdy, o_strobe, o_in_ready, o_busy;
        logic [31:0] cur_data;
        logic [7:0]  o_data;
        done = 1'b0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(posedge clk);
            #1;
            cur_valid = (word_q.size() > 0);
            cur_data  = cur_valid ? word_q[0] : 32'h0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if1.in_valid  = cur_valid && (sel == 0);
            if1.in_data   = W1'(cur_data);
            if1.out_ready = rdy;
            if2.in_valid  = cur_valid && (sel == 1);
            if2.in_data   = W2'(cur_data);
            if2.out_ready = rdy;
            @(negedge clk);
            o_strobe   = (sel == 0) ? if1.out_strobe : if2.out_strobe;
            o_data     = (sel == 0) ? if1.out_data   : if2.out_data;
            o_in_ready = (sel == 0) ? if1.in_ready   : if2.in_ready;
            o_busy     = (sel == 0) ? busy1          : busy2;
            if (o_strobe) begin
                if (!rdy) viol++;
                got_q.push_back(o_data);
                strobe_cyc.push_back(cyc);
            end
            if (o_in_ready && (!cur_valid || o_busy)) viol++;
            if (cur_valid && o_in_ready) begin
                // The previous line must be complete before the next pop.
                if (got_q.size() != exp_q.size()) viol++;
                pop_cyc.push_back(cyc);
                expect_line(word_q.pop_front());
            end else if (!cur_valid && !o_busy && got_q.size() == exp_q.size()) begin
                done = 1'b1;
            end
        end
        check("run_timeout", 32'(done), 32'd1);
        if1.in_valid = 1'b0;
        if2.in_valid = 1'b0;
    endtask

    task automatic compare_lines(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(byte_at(got_q, i)), 32'(exp_q[i]));
        end
        check({tag, "_protocol"}, 32'(viol), 32'd0);
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        if1.in_valid = 1'b0;
        if2.in_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset    = 1'b1;
        seq_m[0] = 8'h00;
        seq_m[1] = 8'h00;
    endtask

    initial begin
        int strobes;
        bit popped;

        reset         = 1'b0;
        if1.in_valid  = 1'b0;
        if1.in_data   = '0;
        if1.out_ready = 1'b1;
        if2.in_valid  = 1'b0;
        if2.in_data   = '0;
        if2.out_ready = 1'b1;
        seq_m[0]      = 8'h00;
        seq_m[1]      = 8'h00;
        sel           = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     32'(busy1),          32'd0);
        check("rst_in_ready", 32'(if1.in_ready),   32'd0);
        check("rst_strobe",   32'(if1.out_strobe), 32'd0);
        check("rst_out_data", 32'(if1.out_data),   32'd0);
        check("rst_busy2",    32'(busy2),          32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single record, out_ready held high: 10 bytes on consecutive cycles
        clear_log();
        sel = 0;
        word_q.push_back(32'hA012345);
        run_words(0, 40);
        compare_lines("t1");
        check("t1_pops",      32'(pop_cyc.size()),    32'd1);
        check("t1_nbytes",    32'(got_q.size()),      32'(BYTES1));
        check("t1_first_a",   32'(byte_at(got_q, PFX)),     32'h61);
        check("t1_space",     32'(byte_at(got_q, PFX + 2)), 32'h20);
        check("t1_lat_first", 32'(int_at(strobe_cyc, 0)),
              32'(int_at(pop_cyc, 0) + 1));
        check("t1_lat_last",  32'(int_at(strobe_cyc, BYTES1 - 1)),
              32'(int_at(pop_cyc, 0) + BYTES1));

        // Same record, out_ready toggling
        clear_log();
        word_q.push_back(32'hA012345);
        run_words(1, 80);
        compare_lines("t2");
        check("t2_pops", 32'(pop_cyc.size()), 32'd1);

        // Three back-to-back records with in_valid held high
        clear_log();
        word_q.push_back(32'hB000001);
        word_q.push_back(32'hC0FFFFF);
        word_q.push_back(32'hDABCDEF);
        run_words(0, 100);
        compare_lines("t3");
        check("t3_pops",  32'(pop_cyc.size()), 32'd3);
        check("t3_gap01", 32'(int_at(pop_cyc, 1) - int_at(pop_cyc, 0)), 32'(BYTES1 + 1));
        check("t3_gap12", 32'(int_at(pop_cyc, 2) - int_at(pop_cyc, 1)), 32'(BYTES1 + 1));

        // Narrow instance: pad nibble, no split, uppercase
        clear_log();
        sel = 1;
        word_q.push_back(32'h3FF);
        run_words(0, 40);
        compare_lines("t4");
        check("t4_nbytes", 32'(got_q.size()), 32'(BYTES2));
        check("t4_top",    32'(byte_at(got_q, PFX)),     32'h33);
        check("t4_mid",    32'(byte_at(got_q, PFX + 1)), 32'h46);

        // Random records with random backpressure, both instances
        clear_log();
        sel = 0;
        for (int i = 0; i < 6; i++) word_q.push_back($urandom & 32'h0FFF_FFFF);
        run_words(2, 2000);
        compare_lines("t5a");
        check("t5a_pops", 32'(pop_cyc.size()), 32'd6);
        clear_log();
        sel = 1;
        for (int i = 0; i < 6; i++) word_q.push_back($urandom & 32'h0000_03FF);
        run_words(2, 2000);
        compare_lines("t5b");
        check("t5b_pops", 32'(pop_cyc.size()), 32'd6);

        // Reset after the 4th byte of a record aborts it
        clear_log();
        sel     = 0;
        strobes = 0;
        popped  = 1'b0;
        for (int c = 0; c < 40 && strobes < 4; c++) begin
            @(posedge clk);
            #1;
            if1.in_valid  = !popped;
            if1.in_data   = W1'(32'h0F1E2D3);
            if1.out_ready = 1'b1;
            @(negedge clk);
            if (if1.in_valid && if1.in_ready) popped = 1'b1;
            if (if1.out_strobe) strobes++;
        end
        check("t6_pre_strobes", 32'(strobes), 32'd4);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        if1.in_valid = 1'b1;
        @(negedge clk);
        check("t6_strobe_now", 32'(if1.out_strobe), 32'd0);
        check("t6_no_pop_now", 32'(if1.in_ready),   32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t6_busy",     32'(busy1),          32'd0);
        check("t6_strobe",   32'(if1.out_strobe), 32'd0);
        check("t6_no_pop",   32'(if1.in_ready),   32'd0);
        check("t6_out_data", 32'(if1.out_data),   32'd0);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        if1.in_valid = 1'b0;
        seq_m[0]     = 8'h00;
        seq_m[1]     = 8'h00;
        @(negedge clk);
        check("t6_idle_strobe", 32'(if1.out_strobe), 32'd0);
        word_q.push_back(32'h5A5A5A5);
        run_words(0, 60);
        compare_lines("t6");
        check("t6_pops", 32'(pop_cyc.size()), 32'd1);

`ifdef HEX_FMT_SEQ_EN
        // 257 records: sequence prefix wraps from ff back to 00
        apply_reset(2);
        clear_log();
        sel = 0;
        for (int i = 0; i < 257; i++) word_q.push_back($urandom & 32'h0FFF_FFFF);
        run_words(0, 257 * (BYTES1 + 1) + 50);
        check("t7_len", 32'(got_q.size()), 32'(exp_q.size()));
        check("t7_p0_hi",   32'(byte_at(got_q, 0)),                32'h30);
        check("t7_p0_lo",   32'(byte_at(got_q, 1)),                32'h30);
        check("t7_p255_hi", 32'(byte_at(got_q, 255 * BYTES1)),     32'h66);
        check("t7_p255_lo", 32'(byte_at(got_q, 255 * BYTES1 + 1)), 32'h66);
        check("t7_p256_hi", 32'(byte_at(got_q, 256 * BYTES1)),     32'h30);
        check("t7_p256_lo", 32'(byte_at(got_q, 256 * BYTES1 + 1)), 32'h30);
        compare_lines("t7");
`else
        // A second reset between records leaves the block ready for a full line
        apply_reset(2);
        clear_log();
        sel = 0;
        word_q.push_back(32'h0000000);
        run_words(0, 40);
        compare_lines("t7");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hex_record_formatter.md
Name: hex_record_formatter

Overview:
Downstream stage of the sensor-timing FIFO. Pops one fixed-width record word at a time and serialises it as an ASCII hex line (MSB nibble first, optional space separator, line terminator) into the UART transmit FIFO byte interface. Respects backpressure on both sides, so records are never dropped or interleaved. Replaces the ad-hoc hex-printing loop in the lighthouse demo top level.

Parameters:
WIDTH, 28, record width in bits; NIBBLES = ceil(WIDTH/4), upper pad bits read as zero
SPLIT, 5, a space is emitted before the last SPLIT hex digits; 0 or >=NIBBLES means no space
UPPERCASE, 0, 1 selects 'A'-'F' for hex digits; 0 selects 'a'-'f'

Ports:
clk  input  1  system clock (48 MHz in the demo)
reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk)
in_data  input  WIDTH  record word from the upstream FIFO read port
in_valid  input  1  upstream FIFO has data (data_available)
in_ready  output  1  pop strobe to the upstream FIFO; the word is consumed when in_valid && in_ready
out_data  output  8  ASCII byte to the UART tx FIFO
out_strobe  output  1  one-cycle write strobe for out_data
out_ready  input  1  UART tx FIFO can accept a byte this cycle (not full)
busy  output  1  high while a record is being emitted

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; in_ready=0, out_strobe=0, out_data=0, busy=0; shift register and counters cleared. Reset mid-record aborts the record: remaining bytes are discarded, no further strobes, and the popped word is lost.
- States: IDLE, DIGIT, SPACE, LF, CR.
- IDLE: in_ready = in_valid (registered pop, one cycle). On pop: capture zero-padded in_data into shift register, digit counter = NIBBLES, busy=1, go to DIGIT.
- DIGIT: when out_ready, emit the top nibble as ASCII, shift left by 4, decrement the counter. After the digit that leaves SPLIT digits remaining, go to SPACE (if the split is enabled); when the counter reaches 0, go to LF.
- SPACE: when out_ready, emit 0x20, then return to DIGIT.
- LF: emit 0x0A. CR: emit 0x0D, then go to IDLE with busy=0. Terminator order is LF then CR, matching the existing host scripts.
- Byte handshake: at most one out_strobe per cycle. A byte is emitted (out_strobe=1, out_data valid the same cycle) only in a cycle where out_ready=1. If out_ready=0, the state holds, out_strobe=0, and out_data may be stale.
- Latency: word popped in cycle T, first byte strobed at T+1 if out_ready. Bytes per record = NIBBLES + (split?1:0) + 2 (10 at defaults). The minimum record period is bytes+1 cycles, because of one IDLE pop cycle.
- in_ready is never high outside IDLE. A new pop occurs only after the CR byte is strobed.
- A nibble value of 0-9 maps to 0x30+n; 10-15 maps to 0x41+n-10 or 0x61+n-10 per UPPERCASE.

Optional Feature:
HEX_FMT_SEQ_EN. When defined: an 8-bit record sequence counter (reset to 0) is emitted as two hex digits plus a space at the start of every line, before the record digits. It increments after each CR, wraps 0xFF->0x00, and adds 3 bytes per record. Undefined: no prefix, counter logic absent.

Decomposition:
- Package hex_fmt_pkg: ASCII constants (SPACE=0x20, LF=0x0A, CR=0x0D, '0', 'a', 'A') and the state encoding.
- Sub-module hex_nibble_to_ascii: combinational 4-bit to 8-bit mapping, parameterised by UPPERCASE. It is reused by the optional sequence prefix.

Test Plan:
- Defaults; in_data=28'hA012345, out_ready=1 -> bytes '3','0'? no: 'A'? see UPPERCASE=0: 'a','0',' ','1','2','3','4','5',0x0A,0x0D on consecutive cycles T+1..T+10; in_ready pulses once.
- Same word with out_ready toggling 1,0,1,0 -> identical 10-byte sequence, no strobe in any cycle with out_ready=0, no duplicated or skipped bytes.
- Three back-to-back words 0xB000001, 0xC0FFFFF, 0xDABCDEF with in_valid held high -> three complete lines in order; exactly one pop per line, and no pop before the preceding CR.
- WIDTH=10, SPLIT=0, in_data=10'h3FF -> '3','f','f',0x0A,0x0D (top pad zero, no space).
- reset driven to 0 after the 4th byte of a record -> out_strobe=0 from the next cycle, busy=0; after release, the next word prints a full fresh line.
- HEX_FMT_SEQ_EN defined, 257 records -> first prefix "00 ", 256th "ff ", 257th "00 ".
